// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounced pushbuttons to per-frame paddle positions.
// Positions step once per vsync rising edge and clamp to the field.
module paddle_ctrl #(
  parameter int SCREEN_HEIGHT = 480,
  parameter int PADDLE_HEIGHT = 50,
  parameter int PADDLE_SPEED  = 4,
  parameter int PADDLE_INIT   = 215,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       btn_up1,
  input  logic       btn_dn1,
  input  logic       btn_up2,
  input  logic       btn_dn2,
  output logic [9:0] paddle1_next,
  output logic [9:0] paddle2_next
);

  localparam int NB = 4;
  localparam int DB = DEBOUNCE_BITS;
  localparam logic [10:0] SPD  = 11'(PADDLE_SPEED);
  localparam logic [10:0] PMAX = 11'(SCREEN_HEIGHT - PADDLE_HEIGHT);
  localparam logic [9:0]  INIT = 10'(PADDLE_INIT);
  localparam logic [DB-1:0] ONE = {{(DB-1){1'b0}}, 1'b1};

  // bit order: 0 up1, 1 dn1, 2 up2, 3 dn2
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] s1_q;
  logic [NB-1:0] s2_q;
  logic [NB-1:0] st_q;
  logic [NB-1:0][DB-1:0] cnt_q;

  logic          vsync_q;
  logic          tick;
  logic          tick_q;
  logic [NB-1:0] dir_q;
  logic [9:0]    p1_q;
  logic [9:0]    p2_q;
  logic [9:0]    p1_d;
  logic [9:0]    p2_d;

  assign btn_raw = {btn_dn2, btn_up2, btn_dn1, btn_up1};
  assign tick    = vsync & ~vsync_q;

  function automatic logic [9:0] next_pos(
    input logic [9:0] p,
    input logic       up,
    input logic       dn
  );
    logic [10:0] sum;
    logic [10:0] pw;
    pw  = {1'b0, p};
    sum = pw + SPD;
    next_pos = p;
    unique case ({up, dn})
      2'b10: begin
        if (pw < SPD) next_pos = '0;
        else          next_pos = 10'(pw - SPD);
      end
      2'b01: begin
        if (sum > PMAX) next_pos = PMAX[9:0];
        else            next_pos = sum[9:0];
      end
      default: next_pos = p;
    endcase
  endfunction

  // two-flop synchroniser for the raw async buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // per-button debounce: a new level must hold for 2^DB cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (s2_q[i] == st_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] != '1) begin
          cnt_q[i] <= cnt_q[i] + ONE;
        end else begin
          st_q[i]  <= s2_q[i];
          cnt_q[i] <= '0;
        end
      end
    end
  end

  // frame tick; levels are latched with it so late changes wait a frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      tick_q  <= 1'b0;
      dir_q   <= '0;
    end else begin
      vsync_q <= vsync;
      tick_q  <= tick;
      if (tick) dir_q <= st_q;
    end
  end

  assign p1_d = tick_q ? next_pos(p1_q, dir_q[0], dir_q[1]) : p1_q;
  assign p2_d = tick_q ? next_pos(p2_q, dir_q[2], dir_q[3]) : p2_q;

  // paddle positions, updated one clk after the tick cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q <= INIT;
      p2_q <= INIT;
    end else begin
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end

  assign paddle1_next = p1_q;
  assign paddle2_next = p2_q;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed and random stimulus against a
// window-based behavioural model of paddle_ctrl.
module tb_paddle_ctrl;

  localparam int DBITS = 4;
  localparam int WIN   = 1 << DBITS;
  localparam int SPEED = 4;
  localparam int INIT  = 215;
  localparam int PMAX  = 430;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vsync = 1'b1;
  logic       btn_up1 = 1'b0;
  logic       btn_dn1 = 1'b0;
  logic       btn_up2 = 1'b0;
  logic       btn_dn2 = 1'b0;
  logic [9:0] paddle1_next;
  logic [9:0] paddle2_next;

  int checks   = 0;
  int failures = 0;

  paddle_ctrl #(
    .SCREEN_HEIGHT(480),
    .PADDLE_HEIGHT(50),
    .PADDLE_SPEED(SPEED),
    .PADDLE_INIT(INIT),
    .DEBOUNCE_BITS(DBITS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .vsync(vsync),
    .btn_up1(btn_up1),
    .btn_dn1(btn_dn1),
    .btn_up2(btn_up2),
    .btn_dn2(btn_dn2),
    .paddle1_next(paddle1_next),
    .paddle2_next(paddle2_next)
  );

  always #5 clk = ~clk;

  // model state
  int       m1 = INIT;
  int       m2 = INIT;
  bit       vprev = 1'b1;
  bit       pend  = 1'b0;
  bit [3:0] pdir  = '0;
  bit [3:0] st    = '0;
  bit [3:0] dly1  = '0;
  bit [3:0] dly2  = '0;
  bit [3:0] hist [WIN];

  function automatic int move(int p, bit up, bit dn);
    if (up && !dn) return (p - SPEED < 0) ? 0 : p - SPEED;
    if (dn && !up) return (p + SPEED > PMAX) ? PMAX : p + SPEED;
    return p;
  endfunction

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 = INIT; m2 = INIT;
      vprev = 1'b1; pend = 1'b0; pdir = '0;
      st = '0; dly1 = '0; dly2 = '0;
      for (int k = 0; k < WIN; k++) hist[k] = '0;
    end else begin
      bit [3:0] s2;
      if (pend) begin
        m1 = move(m1, pdir[0], pdir[1]);
        m2 = move(m2, pdir[2], pdir[3]);
      end
      pend  = vsync && !vprev;
      if (pend) pdir = st;
      vprev = vsync;
      s2   = dly2;
      dly2 = dly1;
      dly1 = {btn_dn2, btn_up2, btn_dn1, btn_up1};
      for (int k = WIN - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s2;
      for (int i = 0; i < 4; i++) begin
        bit all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < WIN; k++)
          if (hist[k][i] == st[i]) all_diff = 1'b0;
        if (all_diff) st[i] = ~st[i];
      end
    end
  end

  always @(negedge clk) begin
    check("p1_model", {22'd0, paddle1_next}, m1);
    check("p2_model", {22'd0, paddle2_next}, m2);
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(int hi, int lo);
    vsync = 1'b1;
    step(hi);
    vsync = 1'b0;
    step(lo);
  endtask

  task automatic frames(int n);
    repeat (n) frame(4, 26);
  endtask

  initial begin
    rst_n = 1'b0;
    step(3);
    check("rst_p1", {22'd0, paddle1_next}, 215);
    check("rst_p2", {22'd0, paddle2_next}, 215);
    #1 rst_n = 1'b1;

    // 1: vsync high at release, then one real edge, no buttons
    step(5);
    check("t1_p1", {22'd0, paddle1_next}, 215);
    vsync = 1'b0;
    step(10);
    vsync = 1'b1;
    step(5);
    check("t1_edge_p1", {22'd0, paddle1_next}, 215);
    check("t1_edge_p2", {22'd0, paddle2_next}, 215);
    vsync = 1'b0;
    step(10);

    // 2: dn1 held, three edges
    btn_dn1 = 1'b1;
    step(20);
    vsync = 1'b1;
    step(1);
    check("t2_lag", {22'd0, paddle1_next}, 215);
    step(1);
    check("t2_f1", {22'd0, paddle1_next}, 219);
    step(2);
    vsync = 1'b0;
    step(20);
    vsync = 1'b1;
    step(2);
    check("t2_f2", {22'd0, paddle1_next}, 223);
    step(2);
    vsync = 1'b0;
    step(20);
    vsync = 1'b1;
    step(2);
    check("t2_f3", {22'd0, paddle1_next}, 227);
    check("t2_p2", {22'd0, paddle2_next}, 215);
    step(2);
    vsync = 1'b0;
    btn_dn1 = 1'b0;
    step(20);

    // 3: up2 glitches shorter than the debounce window
    for (int i = 0; i < 200; i++) begin
      btn_up2 = ((i / 10) % 2) == 0;
      vsync   = (i % 40) < 5;
      step(1);
    end
    btn_up2 = 1'b0;
    vsync   = 1'b0;
    step(5);
    check("t3_p2", {22'd0, paddle2_next}, 215);

    // 4: clamp at both ends
    btn_dn1 = 1'b1;
    step(20);
    frames(50);
    check("t4_427", {22'd0, paddle1_next}, 427);
    frames(1);
    check("t4_430", {22'd0, paddle1_next}, 430);
    frames(69);
    check("t4_hold430", {22'd0, paddle1_next}, 430);
    btn_dn1 = 1'b0;
    btn_up1 = 1'b1;
    step(20);
    frames(107);
    check("t4_2", {22'd0, paddle1_next}, 2);
    frames(1);
    check("t4_0", {22'd0, paddle1_next}, 0);
    frames(11);
    check("t4_hold0", {22'd0, paddle1_next}, 0);

    // 6: reset mid-frame and mid-debounce with paddle at 300
    btn_up1 = 1'b0;
    btn_dn1 = 1'b1;
    step(20);
    frames(75);
    check("t6_300", {22'd0, paddle1_next}, 300);
    btn_up2 = 1'b1;
    step(5);
    vsync = 1'b1;
    #1 rst_n = 1'b0;
    step(1);
    check("t6_rst_p1", {22'd0, paddle1_next}, 215);
    check("t6_rst_p2", {22'd0, paddle2_next}, 215);
    step(2);
    #1 rst_n = 1'b1;
    step(25);
    check("t6_notick", {22'd0, paddle1_next}, 215);
    vsync = 1'b0;
    step(10);
    vsync = 1'b1;
    step(2);
    check("t6_tick", {22'd0, paddle1_next}, 219);
    check("t6_p2", {22'd0, paddle2_next}, 211);
    vsync = 1'b0;
    btn_up2 = 1'b0;
    step(20);

    // 5: both buttons held, then release up1
    btn_up1 = 1'b1;
    step(20);
    frames(4);
    check("t5_hold", {22'd0, paddle1_next}, 219);
    btn_up1 = 1'b0;
    step(20);
    frames(1);
    check("t5_move", {22'd0, paddle1_next}, 223);
    btn_dn1 = 1'b0;

    // random phase
    begin
      int fcnt, flen, fhi;
      fcnt = 0;
      flen = 40;
      fhi  = 4;
      for (int c = 0; c < 6000; c++) begin
        if ($urandom_range(0, 23) == 0) btn_up1 = ~btn_up1;
        if ($urandom_range(0, 23) == 0) btn_dn1 = ~btn_dn1;
        if ($urandom_range(0, 23) == 0) btn_up2 = ~btn_up2;
        if ($urandom_range(0, 23) == 0) btn_dn2 = ~btn_dn2;
        vsync = fcnt < fhi;
        fcnt++;
        if (fcnt >= flen) begin
          fcnt = 0;
          flen = $urandom_range(20, 60);
          fhi  = $urandom_range(1, 8);
        end
        if (c == 3000) begin
          #1 rst_n = 1'b0;
          step(2);
          #1 rst_n = 1'b1;
        end
        step(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
